// File: rtl/hbridge_guard.sv
`default_nettype none
// ============================================================================
// Module      : hbridge_guard
// Description : Output stage for the rover motor drive. Applies commanded
//               H-bridge pairs with enforced dead-time on direction reversal,
//               filters the raw overcurrent comparators into OC flags and
//               kills both enables while any fault is active.
// Revision    : 1.0 - initial release
// ============================================================================
module hbridge_guard #(
    parameter int DEADTIME_CYC = 100000,
    parameter int OC_FILT      = 16,
    parameter int OC_HOLD      = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] in_cmd,
    input  logic [1:0] en_cmd,
    input  logic [1:0] sense,
    output logic [3:0] hb_in,
    output logic [1:0] hb_en,
    output logic [1:0] OC,
    output logic       busy
);

    localparam int DW = (DEADTIME_CYC > 1) ? $clog2(DEADTIME_CYC) : 1;
    localparam int FW = $clog2(OC_FILT + 1);
    localparam int HW = $clog2(OC_HOLD + 1);

    localparam logic [DW-1:0] DEAD_RELOAD = DW'(DEADTIME_CYC - 1);
    localparam logic [FW-1:0] FILT_MAX    = FW'(OC_FILT);
    localparam logic [HW-1:0] HOLD_MAX    = HW'(OC_HOLD);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DEAD = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Sense synchronisers
    // ------------------------------------------------------------------------
    logic [1:0] sense_meta_q;
    logic [1:0] sense_sync_q;

    // Two-flop synchroniser for the asynchronous comparator outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sense_meta_q <= 2'b00;
            sense_sync_q <= 2'b00;
        end else begin
            sense_meta_q <= sense;
            sense_sync_q <= sense_meta_q;
        end
    end

    // ------------------------------------------------------------------------
    // Overcurrent filter / hold per channel
    // ------------------------------------------------------------------------
    logic [1:0] oc_q;
    logic [1:0] oc_d;

    for (genvar i = 0; i < 2; i++) begin : g_sense
        logic [FW-1:0] filt_q;
        logic [FW-1:0] filt_d;
        logic [HW-1:0] hold_q;
        logic [HW-1:0] hold_d;
        logic          oc_nxt;

        // Filter counts consecutive high samples; hold counts consecutive low
        // samples only while the flag is up so a release always starts fresh
        always_comb begin
            filt_d = '0;
            if (sense_sync_q[i]) begin
                filt_d = (filt_q == FILT_MAX) ? filt_q : filt_q + 1'b1;
            end
            hold_d = '0;
            if (oc_q[i] && !sense_sync_q[i]) begin
                hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
            end
            oc_nxt = oc_q[i] ? (hold_d != HOLD_MAX) : (filt_d == FILT_MAX);
        end

        assign oc_d[i] = oc_nxt;

        // Filter and hold counter registers
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                filt_q <= '0;
                hold_q <= '0;
            end else begin
                filt_q <= filt_d;
                hold_q <= hold_d;
            end
        end
    end

    // Registered fault flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oc_q <= 2'b00;
        end else begin
            oc_q <= oc_d;
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel reversal guard
    // ------------------------------------------------------------------------
    logic [3:0] ap_all;
    logic [1:0] run_nxt;
    logic [1:0] dead_nxt;

    for (genvar i = 0; i < 2; i++) begin : g_chan
        logic [1:0]    pair;
        state_t        state_q;
        state_t        state_d;
        logic [1:0]    ap_q;
        logic [1:0]    ap_d;
        logic [1:0]    cmd_last_q;
        logic [DW-1:0] dcnt_q;
        logic [DW-1:0] dcnt_d;

        assign pair = in_cmd[2*i +: 2];

        // Reversal between two driven pairs goes through coast; leaving or
        // entering coast is applied directly. Any command change while coasting
        // restarts the dead period so it is timed from the last change.
        always_comb begin
            state_d = state_q;
            ap_d    = ap_q;
            dcnt_d  = dcnt_q;
            case (state_q)
                ST_RUN: begin
                    if (pair != ap_q) begin
                        if (ap_q == 2'b00 || pair == 2'b00) begin
                            ap_d = pair;
                        end else begin
                            state_d = ST_DEAD;
                            ap_d    = 2'b00;
                            dcnt_d  = DEAD_RELOAD;
                        end
                    end
                end
                ST_DEAD: begin
                    if (pair != cmd_last_q) begin
                        dcnt_d = DEAD_RELOAD;
                    end else if (dcnt_q == '0) begin
                        ap_d    = pair;
                        state_d = ST_RUN;
                    end else begin
                        dcnt_d = dcnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    ap_d    = 2'b00;
                    dcnt_d  = '0;
                end
            endcase
        end

        // Channel state, applied pair, last command and dead counter
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q    <= ST_RUN;
                ap_q       <= 2'b00;
                cmd_last_q <= 2'b00;
                dcnt_q     <= '0;
            end else begin
                state_q    <= state_d;
                ap_q       <= ap_d;
                cmd_last_q <= pair;
                dcnt_q     <= dcnt_d;
            end
        end

        assign ap_all[2*i +: 2] = ap_q;
        assign run_nxt[i]       = (state_d == ST_RUN);
        assign dead_nxt[i]      = (state_d == ST_DEAD);
    end

    // ------------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------------
    logic [1:0] hb_en_q;
    logic       busy_q;

    // Enables track the commands one cycle late; any fault on either channel
    // drops both enables on the same edge the flag rises
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hb_en_q <= 2'b00;
            busy_q  <= 1'b0;
        end else begin
            hb_en_q <= en_cmd & run_nxt & {2{~(|oc_d)}};
            busy_q  <= |dead_nxt;
        end
    end

    assign hb_in = ap_all;
    assign hb_en = hb_en_q;
    assign OC    = oc_q;
    assign busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_hbridge_guard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hbridge_guard
// Description : Scoreboard bench for hbridge_guard. Stimulus drives one
//               vector per cycle and queues the hand-computed outputs for the
//               following edge; a monitor pops and compares after each edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hbridge_guard;

    localparam int DT   = 8;
    localparam int FILT = 4;
    localparam int HOLD = 6;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic [3:0] in_cmd = 4'b0000;
    logic [1:0] en_cmd = 2'b00;
    logic [1:0] sense  = 2'b00;
    logic [3:0] hb_in;
    logic [1:0] hb_en;
    logic [1:0] OC;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_v[$];
    string      exp_n[$];

    hbridge_guard #(
        .DEADTIME_CYC (DT),
        .OC_FILT      (FILT),
        .OC_HOLD      (HOLD)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .in_cmd (in_cmd),
        .en_cmd (en_cmd),
        .sense  (sense),
        .hb_in  (hb_in),
        .hb_en  (hb_en),
        .OC     (OC),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [8:0] got, input logic [8:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got hb_in=%b hb_en=%b OC=%b busy=%b, expected hb_in=%b hb_en=%b OC=%b busy=%b",
                     nm, got[8:5], got[4:3], got[2:1], got[0],
                     want[8:5], want[4:3], want[2:1], want[0]);
        end
    endtask

    // One cycle of stimulus plus the outputs expected after the next edge
    task automatic cyc(input logic [3:0] ic, input logic [1:0] ec, input logic [1:0] sn,
                       input logic [3:0] xi, input logic [1:0] xe, input logic [1:0] xo,
                       input logic xb, input string nm);
        @(negedge clk);
        in_cmd = ic;
        en_cmd = ec;
        sense  = sn;
        exp_v.push_back({xi, xe, xo, xb});
        exp_n.push_back(nm);
    endtask

    // Monitor: compare DUT outputs against the queued expectation after each edge
    initial begin : monitor
        logic [8:0] v;
        string      n;
        forever begin
            @(posedge clk);
            #1;
            if (exp_v.size() > 0) begin
                v = exp_v.pop_front();
                n = exp_n.pop_front();
                chk(n, {hb_in, hb_en, OC, busy}, v);
            end
        end
    end

    initial begin : stimulus
        // Reset state
        repeat (2) cyc(4'b0000, 2'b00, 2'b00, 4'b0000, 2'b00, 2'b00, 1'b0, "reset_state");
        reset = 1'b0;

        // Leaving coast: applied with no dead-time
        cyc(4'b0110, 2'b11, 2'b00, 4'b0110, 2'b11, 2'b00, 1'b0, "first_apply");
        cyc(4'b0110, 2'b11, 2'b00, 4'b0110, 2'b11, 2'b00, 1'b0, "steady");

        // Full reversal on both channels
        repeat (8) cyc(4'b1001, 2'b11, 2'b00, 4'b0000, 2'b00, 2'b00, 1'b1, "rev_dead");
        cyc(4'b1001, 2'b11, 2'b00, 4'b1001, 2'b11, 2'b00, 1'b0, "rev_apply");

        // Reverse back, uninterrupted
        repeat (8) cyc(4'b0110, 2'b11, 2'b00, 4'b0000, 2'b00, 2'b00, 1'b1, "rev2_dead");
        cyc(4'b0110, 2'b11, 2'b00, 4'b0110, 2'b11, 2'b00, 1'b0, "rev2_apply");

        // Reversal interrupted on dead cycle 5: period restarts from the change
        repeat (4) cyc(4'b1001, 2'b11, 2'b00, 4'b0000, 2'b00, 2'b00, 1'b1, "restart_pre");
        repeat (8) cyc(4'b0110, 2'b11, 2'b00, 4'b0000, 2'b00, 2'b00, 1'b1, "restart_post");
        cyc(4'b0110, 2'b11, 2'b00, 4'b0110, 2'b11, 2'b00, 1'b0, "restart_apply");

        // Short glitch on sense A never asserts OC
        repeat (3) cyc(4'b0110, 2'b11, 2'b01, 4'b0110, 2'b11, 2'b00, 1'b0, "glitch");
        repeat (4) cyc(4'b0110, 2'b11, 2'b00, 4'b0110, 2'b11, 2'b00, 1'b0, "glitch_after");

        // Sustained sense A: OC[0] at edge 6, enables killed on that edge
        repeat (5) cyc(4'b0110, 2'b11, 2'b01, 4'b0110, 2'b11, 2'b00, 1'b0, "filt_wait");
        cyc(4'b0110, 2'b11, 2'b01, 4'b0110, 2'b00, 2'b01, 1'b0, "oc_rise");
        repeat (2) cyc(4'b0110, 2'b11, 2'b01, 4'b0110, 2'b00, 2'b01, 1'b0, "oc_held");

        // Release with a blip at low-cycle 4 restarting the hold count
        repeat (3) cyc(4'b0110, 2'b11, 2'b00, 4'b0110, 2'b00, 2'b01, 1'b0, "hold_low");
        cyc(4'b0110, 2'b11, 2'b01, 4'b0110, 2'b00, 2'b01, 1'b0, "hold_blip");
        repeat (7) cyc(4'b0110, 2'b11, 2'b00, 4'b0110, 2'b00, 2'b01, 1'b0, "hold_restart");
        cyc(4'b0110, 2'b11, 2'b00, 4'b0110, 2'b11, 2'b00, 1'b0, "oc_fall");

        // PWM passthrough with one-cycle latency
        cyc(4'b0110, 2'b01, 2'b00, 4'b0110, 2'b01, 2'b00, 1'b0, "pwm_a");
        cyc(4'b0110, 2'b10, 2'b00, 4'b0110, 2'b10, 2'b00, 1'b0, "pwm_b");
        cyc(4'b0110, 2'b00, 2'b00, 4'b0110, 2'b00, 2'b00, 1'b0, "pwm_off");
        cyc(4'b0110, 2'b11, 2'b00, 4'b0110, 2'b11, 2'b00, 1'b0, "pwm_on");

        // Brake on channel A only: A coasts, B keeps running
        repeat (8) cyc(4'b0111, 2'b11, 2'b00, 4'b0100, 2'b10, 2'b00, 1'b1, "brake_dead");
        cyc(4'b0111, 2'b11, 2'b00, 4'b0111, 2'b11, 2'b00, 1'b0, "brake_apply");

        // Entering and leaving coast on channel B: immediate
        cyc(4'b0011, 2'b11, 2'b00, 4'b0011, 2'b11, 2'b00, 1'b0, "coast_b");
        cyc(4'b1011, 2'b11, 2'b00, 4'b1011, 2'b11, 2'b00, 1'b0, "leave_coast_b");

        // Fault on B, then a reversal on B during the fault still goes dead
        repeat (5) cyc(4'b1011, 2'b11, 2'b10, 4'b1011, 2'b11, 2'b00, 1'b0, "ocb_wait");
        cyc(4'b1011, 2'b11, 2'b10, 4'b1011, 2'b00, 2'b10, 1'b0, "ocb_rise");
        repeat (3) cyc(4'b0111, 2'b11, 2'b10, 4'b0011, 2'b00, 2'b10, 1'b1, "dead_fault");

        // Asynchronous reset pulse mid-DEAD, released before the next edge
        @(negedge clk);
        #1 reset = 1'b1;
        #1 chk("reset_async", {hb_in, hb_en, OC, busy}, 9'b0_0000_0000);
        #1 reset = 1'b0;
        in_cmd = 4'b1001;
        en_cmd = 2'b11;
        sense  = 2'b00;
        exp_v.push_back({4'b1001, 2'b11, 2'b00, 1'b0});
        exp_n.push_back("post_reset_apply");
        repeat (2) cyc(4'b1001, 2'b11, 2'b00, 4'b1001, 2'b11, 2'b00, 1'b0, "post_reset_steady");

        // Clean dead period after reset
        repeat (8) cyc(4'b0110, 2'b11, 2'b00, 4'b0000, 2'b00, 2'b00, 1'b1, "post_reset_dead");
        cyc(4'b0110, 2'b11, 2'b00, 4'b0110, 2'b11, 2'b00, 1'b0, "post_reset_rev");

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 20 && exp_v.size() > 0; k++) @(posedge clk);
        #2;
        if (exp_v.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_v.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hbridge_guard.md
Name: hbridge_guard

Overview:
- Output-side stage for the rover motor drive. Sits between the switch/command logic and the H-bridge pins.
- Accepts direction commands (in_cmd) and PWM enables (en_cmd) and drives the bridge with enforced dead-time on direction reversal.
- Filters the raw bridge current-sense comparators and produces the OC[1:0] fault flags that the command logic consumes.

Parameters:
- DEADTIME_CYC, 100000: cycles a channel is held in coast (pair 00, enable low) on a reversal. 1 ms at 100 MHz. Must be ≥1.
- OC_FILT, 16: consecutive high cycles of synchronised sense required to assert OC. Must be ≥1.
- OC_HOLD, 50000: consecutive low cycles of synchronised sense required to deassert OC. Must be ≥1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_cmd  in  4  commanded H-bridge inputs; [1:0] = channel A, [3:2] = channel B
- en_cmd  in  2  commanded enables / PWM; [0] = channel A, [1] = channel B
- sense  in  2  raw asynchronous overcurrent comparators; [0] = A, [1] = B
- hb_in  out  4  registered H-bridge IN1..IN4 pins
- hb_en  out  2  registered H-bridge ENA/ENB pins
- OC  out  2  filtered overcurrent flags, per channel
- busy  out  1  high while either channel is in DEAD

Behaviour:
- Reset (asynchronous): hb_in=0, hb_en=0, OC=0, busy=0, both channels RUN with applied pair=00, all counters=0, sense synchronisers=0.

Sense path:
- Each sense bit passes through a 2-FF synchroniser to give s_sync.
- Per channel: filter counter increments while s_sync=1 and saturates at OC_FILT; it clears to 0 when s_sync=0.
- OC[i] rises on the edge the filter counter reaches OC_FILT. Raw sense high for N≥OC_FILT cycles gives OC high at edge 2+OC_FILT after sense rises.
- While OC[i]=1, a hold counter counts consecutive s_sync=0 cycles and clears on any s_sync=1.
- OC[i] falls on the edge the hold counter reaches OC_HOLD. A glitch shorter than OC_FILT never asserts OC.

Channel FSM (per channel, independent): states RUN and DEAD. Let p = the channel's 2-bit in_cmd pair and ap = the applied pair.
- RUN, p==ap: hold ap.
- RUN, p!=ap, and ap==00 or p==00: ap<=p on the next edge, no dead-time (leaving or entering coast is safe).
- RUN, p!=ap, both nonzero: go to DEAD. ap<=00, dead counter<=DEADTIME_CYC-1.
- DEAD: hb pair=00 and hb_en=0. Counter decrements each cycle.
  - If p changes while in DEAD, the counter reloads to DEADTIME_CYC-1; the restart is measured from the last change.
  - When the counter is 0: ap<=p and go to RUN. The pair stays 00 for exactly DEADTIME_CYC cycles after the last command change.

Outputs:
- hb_in = {apB, apA}, registered.
- hb_en[i] <= en_cmd[i] & (state_i==RUN) & ~(next OC[0] | next OC[1]). Any fault kills both channels on the same edge that OC rises.
- en_cmd to hb_en latency is 1 cycle in RUN. PWM edges pass through unaltered, apart from that delay.
- On the edge that ap changes in RUN, hb_en follows en_cmd normally.
- busy = stateA==DEAD | stateB==DEAD, registered alongside the state.

Simultaneous events:
- A fault during DEAD leaves the FSM running; enables stay low until OC clears.
- A reversal during a fault still enforces dead-time.
- Reset mid-DEAD aborts immediately to the reset values.
- Pair 11 (brake) is a nonzero pair and is handled like any other.

Test Plan (DEADTIME_CYC=8, OC_FILT=4, OC_HOLD=6):
1. Reset released, in_cmd=0110, en_cmd=11 → the edge after the first sample gives hb_in=0110 and hb_en=11. busy stays 0 (first pair leaves coast, no dead-time).
2. From 0110 steady, in_cmd→1001 → for 8 cycles: hb_in=0000, hb_en=00, busy=1. The next edge gives hb_in=1001 and hb_en=11; busy returns to 0.
3. During test 2, in_cmd toggles back to 0110 on dead cycle 5 → dead period restarts. 0000 is held 8 further cycles, then hb_in=0110.
4. sense[0] high for 3 cycles then low → OC stays 00 and hb_en is unaffected. sense[0] held high → OC[0]=1 at edge 6 after rising, and hb_en=00 on that edge.
5. After test 4 fault, sense[0] low → OC[0] falls after 6 consecutive synced-low cycles. A single high blip at low-cycle 4 restarts the hold count. hb_en follows en_cmd again once OC=00.
6. Assert reset in the middle of DEAD with OC[1]=1 → outputs go to 0 immediately. After release: OC=00, busy=0, and the next command is applied with no dead-time.
